// File: rtl/rot_cmd_parser.sv
// rot_cmd_parser: turns an ASCII stream of "L<n>\n" / "R<n>\n" lines
// into registered rotation commands with a valid/ready handshake.
// Ports:
//   clock, reset_n       single clock, async active-low reset
//   in_valid/in_byte/    byte stream in; in_last marks the final byte
//   in_last/in_ready     (in_ready drops once the stream is done)
//   out_ready            consumer accepts the pending command
//   en/dir/rot           command valid, direction, magnitude
//   cmd_count            commands retired by the consumer (wraps)
//   err                  sticky syntax/overflow error
//   done                 stream finished and last command retired

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
} DIR_T;

module rot_cmd_parser (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     in_valid,
    input  logic [7:0]               in_byte,
    input  logic                     in_last,
    output logic                     in_ready,
    input  logic                     out_ready,
    output logic                     en,
    output DIR_T                     dir,
    output logic [`DATA_WIDTH-1:0]   rot,
    output logic [`DATA_WIDTH-1:0]   cmd_count,
    output logic                     err,
    output logic                     done
);

    localparam int W = `DATA_WIDTH;

    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_L  = 8'h4C;
    localparam logic [7:0] CH_R  = 8'h52;
    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_9  = 8'h39;

    typedef enum logic [1:0] {
        IDLE,
        DIGITS,
        SKIP,
        DONE
    } state_t;

    state_t         state;
    state_t         state_n;
    logic [W-1:0]   acc;
    logic [W-1:0]   acc_n;
    logic           have;
    logic           have_n;
    DIR_T           cdir;
    DIR_T           cdir_n;
    logic           emit;
    logic [W-1:0]   emit_rot;
    logic           err_set;
    logic           accept;
    logic [W+3:0]   wide;
    logic [3:0]     digit;
    logic           is_digit;
    logic           is_lf;
    logic           is_cr;
    logic           is_l;
    logic           is_r;

    // A byte may enter while the pending command retires this cycle.
    // Once DONE, nothing more is accepted, even before the last
    // command has left.
    assign in_ready = (state != DONE) && (!en || out_ready);
    assign done     = (state == DONE) && !en;
    assign accept   = in_valid && in_ready;

    assign is_digit = (in_byte >= CH_0) && (in_byte <= CH_9);
    assign is_lf    = (in_byte == CH_LF);
    assign is_cr    = (in_byte == CH_CR);
    assign is_l     = (in_byte == CH_L);
    assign is_r     = (in_byte == CH_R);

    // ASCII digits sit at 0x30..0x39, so the low nibble is the value.
    assign digit = in_byte[3:0];

    // acc*10 + digit with 4 spare bits: anything in the top nibble
    // means the true value no longer fits in W bits.
    assign wide = ({4'b0, acc} << 3) + ({4'b0, acc} << 1)
                + {{W{1'b0}}, digit};

    always_comb begin
        state_n  = state;
        acc_n    = acc;
        have_n   = have;
        cdir_n   = cdir;
        emit     = 1'b0;
        emit_rot = acc;
        err_set  = 1'b0;
        if (accept) begin
            unique case (state)
                IDLE: begin
                    unique case (1'b1)
                        is_l, is_r: begin
                            cdir_n  = is_r ? RIGHT : LEFT;
                            acc_n   = '0;
                            have_n  = 1'b0;
                            state_n = DIGITS;
                        end
                        is_lf, is_cr: ;
                        default: begin
                            err_set = 1'b1;
                            state_n = SKIP;
                        end
                    endcase
                end
                DIGITS: begin
                    if (is_digit) begin
                        acc_n   = wide[W-1:0];
                        have_n  = 1'b1;
                        err_set = |wide[W+3:W];
                    end else begin
                        if (have) begin
                            emit = 1'b1;
                        end else begin
                            err_set = 1'b1;
                        end
                        state_n = is_lf ? IDLE : SKIP;
                    end
                end
                SKIP: begin
                    if (is_lf) begin
                        state_n = IDLE;
                    end
                end
                default: ;
            endcase
            // End of stream flushes an unterminated number.
            if (in_last) begin
                if (state_n == DIGITS && have_n) begin
                    emit     = 1'b1;
                    emit_rot = acc_n;
                end
                state_n = DONE;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            acc       <= '0;
            have      <= 1'b0;
            cdir      <= LEFT;
            en        <= 1'b0;
            dir       <= LEFT;
            rot       <= '0;
            cmd_count <= '0;
            err       <= 1'b0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            have  <= have_n;
            cdir  <= cdir_n;
            if (emit) begin
                en  <= 1'b1;
                dir <= cdir_n;
                rot <= emit_rot;
            end else if (out_ready) begin
                en  <= 1'b0;
            end
            if (en && out_ready) begin
                cmd_count <= cmd_count + 1'b1;
            end
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rot_cmd_parser.sv
// tb_rot_cmd_parser: scoreboard bench for rot_cmd_parser; a line-level
// parser model queues expected commands, a monitor retires them.

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_rot_cmd_parser;

    localparam int W = `DATA_WIDTH;

    typedef logic [7:0] bq_t[$];

    logic           clock = 1'b0;
    logic           reset_n = 1'b0;
    logic           in_valid = 1'b0;
    logic [7:0]     in_byte = 8'h00;
    logic           in_last = 1'b0;
    logic           out_ready = 1'b1;
    logic           in_ready;
    logic           en;
    DIR_T           dir;
    logic [W-1:0]   rot;
    logic [W-1:0]   cmd_count;
    logic           err;
    logic           done;

    int             vectors = 0;
    int             miscompares = 0;
    logic [W:0]     exp_q[$];
    bit             m_err = 1'b0;
    int             m_cnt = 0;
    int             mode = 0;
    bit             prev_stall = 1'b0;
    DIR_T           prev_dir = LEFT;
    logic [W-1:0]   prev_rot = '0;

    rot_cmd_parser dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_byte   (in_byte),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .en        (en),
        .dir       (dir),
        .rot       (rot),
        .cmd_count (cmd_count),
        .err       (err),
        .done      (done)
    );

    always #5 clock = ~clock;

    // mode 0: always ready, 1: random, 2: stalled
    always @(posedge clock) begin
        #1;
        if (mode == 0) out_ready = 1'b1;
        else if (mode == 2) out_ready = 1'b0;
        else out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops one expected command per handshake and checks
    // that a stalled command holds still.
    always @(negedge clock) begin
        logic [W:0] e;
        if (reset_n) begin
            if (prev_stall) begin
                chk("hold_en", 64'(en), 64'd1);
                chk("hold_dir", 64'(dir), 64'(prev_dir));
                chk("hold_rot", 64'(rot), 64'(prev_rot));
            end
            if (en && out_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_cmd: got dir=%0d rot=%0d expected none",
                             dir, rot);
                end else begin
                    e = exp_q.pop_front();
                    chk("cmd_dir", 64'(dir), 64'(e[W]));
                    chk("cmd_rot", 64'(rot), 64'(e[W-1:0]));
                end
            end
            prev_stall = en && !out_ready;
            prev_dir   = dir;
            prev_rot   = rot;
        end else begin
            prev_stall = 1'b0;
        end
    end

    function automatic bq_t str2q(input string str);
        bq_t q;
        for (int i = 0; i < str.len(); i++) q.push_back(str[i]);
        return q;
    endfunction

    function automatic bq_t rnd_stream();
        bq_t q;
        int n = $urandom_range(8, 30);
        for (int i = 0; i < n; i++) begin
            int r = $urandom_range(0, 15);
            case (r)
                0, 1:    q.push_back(8'h4C);
                2, 3:    q.push_back(8'h52);
                10, 11:  q.push_back(8'h0A);
                12:      q.push_back(8'h0D);
                13:      q.push_back(8'h58);
                default: q.push_back(8'h30 + 8'($urandom_range(0, 9)));
            endcase
        end
        return q;
    endfunction

    // Line-level reference: each LF-delimited line is judged as a
    // whole. Leading CRs are blank; a line must start with L/R and a
    // digit run; anything after the number is ignored.
    task automatic model(input bq_t s, input bit last);
        int     i = 0;
        int     n = s.size();
        bit     d;
        longint v;
        int     nd;
        longint lim = longint'(1) << W;
        while (i < n) begin
            while (i < n && s[i] == 8'h0D) i++;
            if (i >= n) break;
            if (s[i] == 8'h0A) begin
                i++;
                continue;
            end
            if (s[i] != 8'h4C && s[i] != 8'h52) begin
                m_err = 1'b1;
            end else begin
                d  = (s[i] == 8'h52);
                i++;
                v  = 0;
                nd = 0;
                while (i < n && s[i] >= 8'h30 && s[i] <= 8'h39) begin
                    v = v * 10 + longint'(s[i] - 8'h30);
                    if (v >= lim) begin
                        m_err = 1'b1;
                        v = v % lim;
                    end
                    nd++;
                    i++;
                end
                if (nd > 0 && (i < n || last)) begin
                    exp_q.push_back({d, v[W-1:0]});
                    m_cnt++;
                end else if (nd == 0 && i < n) begin
                    m_err = 1'b1;
                end
            end
            while (i < n && s[i] != 8'h0A) i++;
            i++;
        end
    endtask

    task automatic send(input bq_t s, input bit last, input bit gaps);
        for (int i = 0; i < s.size(); i++) begin
            int t = 0;
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clock);
                    #1;
                end
            end
            in_valid = 1'b1;
            in_byte  = s[i];
            in_last  = last && (i == s.size() - 1);
            @(negedge clock);
            while (!in_ready && t < 300) begin
                @(negedge clock);
                t++;
            end
            if (!in_ready) begin
                vectors++;
                miscompares++;
                $display("FAIL send_timeout: got in_ready=0 expected 1");
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
            @(posedge clock);
            #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic scn(input bq_t q, input bit last, input bit gaps);
        model(q, last);
        send(q, last, gaps);
    endtask

    task automatic finish_scn(input bit fin);
        int t = 0;
        while ((exp_q.size() != 0 || en) && t < 500) begin
            @(negedge clock);
            t++;
        end
        @(negedge clock);
        chk("drain_left", 64'(exp_q.size()), 64'd0);
        chk("err", 64'(err), 64'(m_err));
        chk("cmd_count", 64'(cmd_count), 64'(W'(m_cnt)));
        chk("done", 64'(done), 64'(fin));
        if (fin) chk("ready_done", 64'(in_ready), 64'd0);
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        #3;
        chk("rst_en", 64'(en), 64'd0);
        chk("rst_dir", 64'(dir), 64'(LEFT));
        chk("rst_rot", 64'(rot), 64'd0);
        chk("rst_cnt", 64'(cmd_count), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        exp_q.delete();
        m_err = 1'b0;
        m_cnt = 0;
        repeat (2) @(posedge clock);
        #2;
        reset_n = 1'b1;
        #1;
        chk("ready_after_rst", 64'(in_ready), 64'd1);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Two commands, one cycle after each LF.
        mode = 0;
        do_reset();
        scn(str2q("L68\n"), 1'b0, 1'b0);
        @(negedge clock);
        chk("lat1_en", 64'(en), 64'd1);
        chk("lat1_dir", 64'(dir), 64'(LEFT));
        chk("lat1_rot", 64'(rot), 64'd68);
        @(posedge clock);
        #1;
        scn(str2q("R30\n"), 1'b0, 1'b0);
        @(negedge clock);
        chk("lat2_en", 64'(en), 64'd1);
        chk("lat2_dir", 64'(dir), 64'(RIGHT));
        chk("lat2_rot", 64'(rot), 64'd30);
        @(posedge clock);
        #1;
        finish_scn(1'b0);

        // Final byte is a digit.
        do_reset();
        scn(str2q("R5"), 1'b1, 1'b0);
        finish_scn(1'b1);

        // Syntax errors around one good command.
        do_reset();
        scn(str2q("X12\nL\nL3\r\n"), 1'b0, 1'b0);
        finish_scn(1'b0);

        // Back-pressure holds the first command.
        do_reset();
        mode = 2;
        model(str2q("L1\nL2\n"), 1'b0);
        fork
            send(str2q("L1\nL2\n"), 1'b0, 1'b0);
            begin
                int t = 0;
                while (!en && t < 50) begin
                    @(negedge clock);
                    t++;
                end
                repeat (4) begin
                    @(negedge clock);
                    chk("stall_en", 64'(en), 64'd1);
                    chk("stall_dir", 64'(dir), 64'(LEFT));
                    chk("stall_rot", 64'(rot), 64'd1);
                    chk("stall_ready", 64'(in_ready), 64'd0);
                end
                mode = 0;
            end
        join
        finish_scn(1'b0);

        // 2^W wraps to zero with an error.
        do_reset();
        scn(str2q("R4294967296\n"), 1'b0, 1'b0);
        finish_scn(1'b0);

        // Reset discards a stalled command.
        do_reset();
        mode = 2;
        send(str2q("L9\n"), 1'b0, 1'b0);
        @(negedge clock);
        chk("pend_en", 64'(en), 64'd1);
        mode = 0;
        @(posedge clock);
        #1;
        do_reset();

        // Reset in the middle of a number.
        send(str2q("L12"), 1'b0, 1'b0);
        do_reset();
        scn(str2q("R7\n"), 1'b0, 1'b0);
        finish_scn(1'b0);

        // Random streams, random gaps and back-pressure.
        for (int k = 0; k < 40; k++) begin
            bit last = ($urandom_range(0, 1) == 1);
            do_reset();
            mode = 1;
            scn(rnd_stream(), last, 1'b1);
            finish_scn(last);
            mode = 0;
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
